// File: rtl/sync_ram_ctrl_if.sv
// Request/response bundle for sync_ram_ctrl.
// master drives requests, slave returns in-order responses.
interface sync_ram_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_write;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic [DATA_WIDTH/8-1:0] req_be;
    logic                    rsp_valid;
    logic                    rsp_write;
    logic [DATA_WIDTH-1:0]   rsp_rdata;
    logic                    rsp_err;

    modport master (
        output req_valid, req_write, req_addr,
        output req_wdata, req_be,
        input  req_ready,
        input  rsp_valid, rsp_write, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr,
        input  req_wdata, req_be,
        output req_ready,
        output rsp_valid, rsp_write, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/sync_ram_ctrl.sv
// Single-port word memory with byte lanes, init sweep,
// range checking and a fixed-latency in-order response pipe.
module sync_ram_ctrl #(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 4096,
    parameter int ADDR_WIDTH   = $clog2(DEPTH),
    parameter int READ_LATENCY = 2,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic             clock,
    input  logic             reset,
    sync_ram_ctrl_if.slave   bus,
    output logic             init_done
);
    localparam int NB = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] LAST =
        ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] DEPTH_W =
        (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    typedef struct packed {
        logic                  v;
        logic                  wr;
        logic                  err;
        logic [DATA_WIDTH-1:0] data;
    } stage_t;

    state_t                state, state_nx;
    logic [ADDR_WIDTH-1:0] cnt, cnt_nx;
    logic                  init_we;
    logic                  acc;
    logic                  in_rng;
    logic                  wr_en;
    logic                  rd_en;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    stage_t                pipe [READ_LATENCY+1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_INIT;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        init_we  = 1'b0;
        unique case (state)
            S_INIT: begin
                init_we = 1'b1;
                cnt_nx  = cnt + 1'b1;
                if (cnt == LAST) begin
                    state_nx = S_RUN;
                    cnt_nx   = '0;
                end
            end
            S_RUN: begin
                state_nx = S_RUN;
            end
            default: begin
                state_nx = S_INIT;
            end
        endcase
    end

    assign bus.req_ready = (state == S_RUN);
    assign init_done     = (state == S_RUN);

    assign acc    = bus.req_valid && bus.req_ready;
    assign in_rng = {1'b0, bus.req_addr} < DEPTH_W;
    assign wr_en  = acc && bus.req_write && in_rng;
    assign rd_en  = acc && !bus.req_write && in_rng;

    // Storage is never reset; the sweep owns it until RUN.
    always_ff @(posedge clock) begin
        if (init_we) begin
            mem[cnt] <= INIT_VALUE;
        end else if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.req_be[i]) begin
                    mem[bus.req_addr][8*i +: 8] <=
                        bus.req_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i <= READ_LATENCY; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0].v    <= acc;
            pipe[0].wr   <= acc && bus.req_write;
            pipe[0].err  <= acc && !in_rng;
            pipe[0].data <= rd_en ? mem[bus.req_addr] : '0;
            for (int i = 1; i <= READ_LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign bus.rsp_valid = pipe[READ_LATENCY].v;
    assign bus.rsp_write = pipe[READ_LATENCY].wr;
    assign bus.rsp_err   = pipe[READ_LATENCY].err;
    assign bus.rsp_rdata = pipe[READ_LATENCY].data;
endmodule

// File: doc/sync_ram_ctrl.md
Name: sync_ram_ctrl

Overview:
- Parametrised successor to the team's single-port byte memory. Generalised data width and depth, byte-lane write enables, and a configurable read-latency pipeline.
- Uses a valid/ready request channel and an in-order response channel, with out-of-range address detection.
- After reset, a hardware init sweep writes INIT_VALUE to every location. Sits between bus masters and on-chip storage.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8
- DEPTH, 4096, number of words; need not be a power of two
- ADDR_WIDTH, $clog2(DEPTH), address width
- READ_LATENCY, 2, cycles from request accept to rsp_valid; legal range 1..4
- INIT_VALUE, 0, DATA_WIDTH-bit value written to every word by the init sweep

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request this cycle
- req_write  input  1  1 = write, 0 = read
- req_addr  input  ADDR_WIDTH  word address
- req_wdata  input  DATA_WIDTH  write data
- req_be  input  DATA_WIDTH/8  byte-lane write enables (bit i covers bits 8i+7:8i)
- rsp_valid  output  1  one-cycle response pulse
- rsp_write  output  1  response belongs to a write
- rsp_rdata  output  DATA_WIDTH  read data; 0 for writes and errors
- rsp_err  output  1  address was >= DEPTH
- init_done  output  1  init sweep complete

Behaviour:
- Reset (reset low, asynchronous):
  - FSM goes to INIT, init counter = 0, all latency-pipeline valid bits cleared.
  - Outputs: req_ready=0, rsp_valid=0, rsp_write=0, rsp_rdata=0, rsp_err=0, init_done=0.
  - Storage contents are not reset directly.
- FSM states: INIT, RUN.
- INIT:
  - Each cycle writes INIT_VALUE to word[counter], then increments the counter.
  - After writing DEPTH-1, moves to RUN. init_done=1 and req_ready=1 from the first RUN cycle.
  - The sweep takes exactly DEPTH cycles after reset deasserts.
  - Requests presented during INIT are not accepted; req_ready=0.
- RUN:
  - req_ready=1 every cycle (no backpressure).
  - A request is accepted when req_valid && req_ready; at most one per cycle.
- Write, addr < DEPTH:
  - At the accept edge, only lanes with req_be[i]=1 are updated; other lanes are unchanged.
  - req_be=0 is a legal no-op write and still produces a response.
- Read, addr < DEPTH: word sampled at the accept edge, then carried through the pipeline.
- addr >= DEPTH: no storage access; response has rsp_err=1 and rsp_rdata=0.
- Responses:
  - rsp_valid pulses exactly READ_LATENCY cycles after the accept edge, for both reads and writes.
  - Responses are strictly in order, one per accepted request.
  - Back-to-back accepts give back-to-back rsp_valid.
- Hazards:
  - A read accepted the cycle after a write to the same address returns the new merged data.
  - A read and write in the same cycle is impossible (single request).
- Reset mid-operation: in-flight responses are discarded (no rsp_valid), the block re-enters INIT, and the full sweep reruns.
- Address wrap: none. Addresses >= DEPTH are flagged with rsp_err, never aliased.
- Width rules:
  - rsp_rdata is exactly DATA_WIDTH bits.
  - The init counter is ADDR_WIDTH bits and is compared against DEPTH-1, so non-power-of-two DEPTH never wraps past DEPTH-1.

Test Plan:
- DEPTH=16, INIT_VALUE=32'hA5A5A5A5: release reset, hold req_valid=1 -> req_ready=0 and init_done=0 for exactly 16 cycles, then both 1. Reads of addresses 0..15 all return 32'hA5A5A5A5.
- READ_LATENCY=2: write 0xDEADBEEF to addr 5 with be=4'hF, then read addr 5 on the next cycle -> rsp_valid at accept+2 for each request, in order; read returns 0xDEADBEEF with rsp_write=0.
- Byte enables: addr 7 holds 0x11223344; write 0xAABBCCDD with be=4'b0101 -> subsequent read returns 0x11BB33DD.
- DEPTH=12, read addr 12 and write addr 15 -> both responses have rsp_err=1 and rsp_rdata=0. A following read of addr 0 is unaffected and rsp_err=0.
- Reset mid-stream:
  - Accept 3 reads back-to-back, then pulse reset low one cycle later -> none of the pending rsp_valid pulses appear; init_done=0.
  - The init sweep reruns for DEPTH cycles, then normal operation resumes.
- Sweep READ_LATENCY over 1, 3 and 4 with a 20-request random stream -> every response lands at exactly accept+READ_LATENCY, with rdata matching a reference model.
